// File: rtl/esl_clk_check_pkg.sv
// Shared types and constants for the clock-checker measurement core.
package esl_clk_check_pkg;

    localparam int DEF_CNT_W = 24;
    localparam int STATUS_W  = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_EVAL    = 2'd2
    } state_e;

    // core_status field positions
    localparam int ST_RUN_BIT   = 0;
    localparam int ST_ERR_BIT   = 1;
    localparam int ST_LOW_BIT   = 2;
    localparam int ST_HIGH_BIT  = 3;
    localparam int ST_VALID_BIT = 4;
    localparam int ST_STATE_LSB = 5;
    localparam int ST_STATE_MSB = 6;
    localparam int ST_FAIL_LSB  = 8;
    localparam int ST_FAIL_MSB  = 15;
    localparam int ST_WIN_LSB   = 16;
    localparam int ST_WIN_MSB   = 23;

endpackage

// File: rtl/esl_clk_check_edge_cnt.sv
// Edge detector on the synchronised CUT toggle plus a saturating edge counter.
module esl_clk_check_edge_cnt
    import esl_clk_check_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cut_tgl,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] cut_sum
);

    logic             cut_tgl_d_q, cut_tgl_d_d;
    logic             cut_edge;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cut_sum is the count including this cycle's edge, so the window capture sees it too
    always_comb begin
        cut_tgl_d_d = cut_tgl;
        cut_edge    = cut_tgl ^ cut_tgl_d_q;
        cut_sum     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(cut_edge);
        cnt_d       = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = CNT_W'(cut_edge);
        end else if (inc) begin
            cnt_d = cut_sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cut_tgl_d_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            cut_tgl_d_q <= cut_tgl_d_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: rtl/esl_clk_check_core.sv
// Clock-checker core: counts CUT edges over a fixed reference window,
// range-checks each window and raises a sticky error after repeated failures.
module esl_clk_check_core
    import esl_clk_check_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int REF_TC     = 100000,
    parameter int MIN_CNT    = 45000,
    parameter int MAX_CNT    = 55000,
    parameter int ERR_THRESH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                cut_tgl,
    input  logic                err_clear,
    output logic [STATUS_W-1:0] core_status,
    output logic [CNT_W-1:0]    cut_count_store,
    output logic [CNT_W-1:0]    ref_clk_tc_reg,
    output logic                clk_err,
    output logic                meas_done
);

    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REF_TC - 1);
    localparam logic [CNT_W-1:0] REF_VAL  = CNT_W'(REF_TC);
    localparam logic [CNT_W-1:0] MIN_VAL  = CNT_W'(MIN_CNT);
    localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(MAX_CNT);
    localparam logic [7:0]       THRESH_V = 8'(ERR_THRESH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [CNT_W-1:0] store_q, store_d;
    logic [CNT_W-1:0] ref_tc_q, ref_tc_d;
    logic             meas_done_q, meas_done_d;
    logic             too_low_q, too_low_d;
    logic             too_high_q, too_high_d;
    logic             clk_err_q, clk_err_d;
    logic             valid_q, valid_d;
    logic [7:0]       fail_cnt_q, fail_cnt_d;
    logic [7:0]       win_cnt_q, win_cnt_d;
    logic             fail_now;
    logic [CNT_W-1:0] cut_sum;

    esl_clk_check_edge_cnt #(
        .CNT_W (CNT_W)
    ) u_edge_cnt (
        .clk     (clk),
        .reset   (reset),
        .cut_tgl (cut_tgl),
        .clr     (state_q == ST_IDLE),
        .load    (state_q == ST_EVAL),
        .inc     ((state_q == ST_MEASURE) && enable),
        .cut_sum (cut_sum)
    );

    // err_clear is applied first so that an EVAL reaching the threshold overrides it
    always_comb begin
        state_d     = state_q;
        ref_cnt_d   = ref_cnt_q;
        store_d     = store_q;
        ref_tc_d    = ref_tc_q;
        meas_done_d = 1'b0;
        too_low_d   = too_low_q;
        too_high_d  = too_high_q;
        clk_err_d   = clk_err_q;
        valid_d     = valid_q;
        fail_cnt_d  = fail_cnt_q;
        win_cnt_d   = win_cnt_q;
        fail_now    = 1'b0;

        if (err_clear) begin
            clk_err_d  = 1'b0;
            fail_cnt_d = 8'd0;
        end

        case (state_q)
            ST_IDLE: begin
                ref_cnt_d = '0;
                if (enable) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    ref_cnt_d = ref_cnt_q + 1'b1;
                    if (ref_cnt_q == REF_LAST) begin
                        store_d  = cut_sum;
                        ref_tc_d = REF_VAL;
                        state_d  = ST_EVAL;
                    end
                end
            end
            ST_EVAL: begin
                meas_done_d = 1'b1;
                too_low_d   = store_q < MIN_VAL;
                too_high_d  = store_q > MAX_VAL;
                fail_now    = too_low_d | too_high_d;
                fail_cnt_d  = fail_now ? ((&fail_cnt_q) ? fail_cnt_q : fail_cnt_q + 8'd1) : 8'd0;
                if (fail_cnt_d >= THRESH_V) clk_err_d = 1'b1;
                valid_d     = 1'b1;
                win_cnt_d   = win_cnt_q + 8'd1;
                ref_cnt_d   = '0;
                state_d     = enable ? ST_MEASURE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ref_cnt_q   <= '0;
            store_q     <= '0;
            ref_tc_q    <= '0;
            meas_done_q <= 1'b0;
            too_low_q   <= 1'b0;
            too_high_q  <= 1'b0;
            clk_err_q   <= 1'b0;
            valid_q     <= 1'b0;
            fail_cnt_q  <= 8'd0;
            win_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            ref_cnt_q   <= ref_cnt_d;
            store_q     <= store_d;
            ref_tc_q    <= ref_tc_d;
            meas_done_q <= meas_done_d;
            too_low_q   <= too_low_d;
            too_high_q  <= too_high_d;
            clk_err_q   <= clk_err_d;
            valid_q     <= valid_d;
            fail_cnt_q  <= fail_cnt_d;
            win_cnt_q   <= win_cnt_d;
        end
    end

    always_comb begin
        core_status                            = '0;
        core_status[ST_RUN_BIT]                = (state_q != ST_IDLE);
        core_status[ST_ERR_BIT]                = clk_err_q;
        core_status[ST_LOW_BIT]                = too_low_q;
        core_status[ST_HIGH_BIT]               = too_high_q;
        core_status[ST_VALID_BIT]              = valid_q;
        core_status[ST_STATE_MSB:ST_STATE_LSB] = state_q;
        core_status[ST_FAIL_MSB:ST_FAIL_LSB]   = fail_cnt_q;
        core_status[ST_WIN_MSB:ST_WIN_LSB]     = win_cnt_q;
    end

    assign cut_count_store = store_q;
    assign ref_clk_tc_reg  = ref_tc_q;
    assign clk_err         = clk_err_q;
    assign meas_done       = meas_done_q;

endmodule

// File: tb/tb_esl_clk_check_core.sv
// Self-checking bench: randomized and directed stimulus against a window-level reference model.
module tb_esl_clk_check_core;

    localparam int CNT_W  = 24;
    localparam int REF_TC = 100;
    localparam int MIN_C  = 45;
    localparam int MAX_C  = 55;
    localparam int THRESH = 2;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             cut_tgl = 1'b0;
    logic             err_clear = 1'b0;
    logic [23:0]      core_status;
    logic [CNT_W-1:0] cut_count_store;
    logic [CNT_W-1:0] ref_clk_tc_reg;
    logic             clk_err;
    logic             meas_done;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;
    int tgl_period = 0;
    int tgl_phase  = 0;

    // reference model state: a window is REF_TC counting cycles followed by one evaluation cycle
    bit m_run, m_prev, m_done, m_low, m_high, m_err, m_valid;
    int m_pos, m_acc, m_store, m_reftc, m_fail, m_wins;

    esl_clk_check_core #(
        .CNT_W      (CNT_W),
        .REF_TC     (REF_TC),
        .MIN_CNT    (MIN_C),
        .MAX_CNT    (MAX_C),
        .ERR_THRESH (THRESH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .cut_tgl         (cut_tgl),
        .err_clear       (err_clear),
        .core_status     (core_status),
        .cut_count_store (cut_count_store),
        .ref_clk_tc_reg  (ref_clk_tc_reg),
        .clk_err         (clk_err),
        .meas_done       (meas_done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        int  e, old_fail;
        bit  bad;
        if (reset) begin
            m_run = 0; m_prev = 0; m_done = 0; m_low = 0; m_high = 0; m_err = 0; m_valid = 0;
            m_pos = 0; m_acc = 0; m_store = 0; m_reftc = 0; m_fail = 0; m_wins = 0;
        end else begin
            e        = int'(cut_tgl ^ m_prev);
            m_prev   = cut_tgl;
            m_done   = 0;
            old_fail = m_fail;
            if (err_clear) begin
                m_err  = 0;
                m_fail = 0;
            end
            if (!m_run) begin
                m_acc = 0;
                m_pos = 0;
                if (enable) m_run = 1;
            end else if (m_pos < REF_TC) begin
                if (!enable) begin
                    m_run = 0;
                end else begin
                    m_acc = (m_acc + e > SAT) ? SAT : m_acc + e;
                    if (m_pos == REF_TC - 1) begin
                        m_store = m_acc;
                        m_reftc = REF_TC;
                    end
                    m_pos++;
                end
            end else begin
                m_done  = 1;
                m_low   = m_store < MIN_C;
                m_high  = m_store > MAX_C;
                bad     = m_low | m_high;
                m_fail  = bad ? ((old_fail >= 255) ? 255 : old_fail + 1) : 0;
                if (m_fail >= THRESH) m_err = 1;
                m_valid = 1;
                m_wins  = (m_wins + 1) % 256;
                m_acc   = e;
                m_pos   = 0;
                m_run   = enable;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0]  st;
        logic [23:0] exp_status;
        if (chk_en) begin
            st = !m_run ? 2'd0 : ((m_pos < REF_TC) ? 2'd1 : 2'd2);
            exp_status = {8'(m_wins), 8'(m_fail), 1'b0, st, m_valid, m_high, m_low, m_err, m_run};
            n_vec++;
            if (core_status !== exp_status) begin
                n_miss++;
                $display("[TB] FAIL model_status: got 0x%0h, expected 0x%0h at %0t", core_status, exp_status, $time);
            end
            if (cut_count_store !== CNT_W'(m_store)) begin
                n_miss++;
                $display("[TB] FAIL model_store: got %0d, expected %0d at %0t", cut_count_store, m_store, $time);
            end
            if (ref_clk_tc_reg !== CNT_W'(m_reftc)) begin
                n_miss++;
                $display("[TB] FAIL model_reftc: got %0d, expected %0d at %0t", ref_clk_tc_reg, m_reftc, $time);
            end
            if (clk_err !== m_err || meas_done !== m_done) begin
                n_miss++;
                $display("[TB] FAIL model_err_done: got %b/%b, expected %b/%b at %0t", clk_err, meas_done, m_err, m_done, $time);
            end
        end
    end

    // CUT toggle source: 0 = stuck, 1..4 = fixed toggle period, 5 = random
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (tgl_period == 5) begin
                cut_tgl = cut_tgl ^ 1'($urandom_range(0, 1));
            end else if (tgl_period != 0) begin
                tgl_phase++;
                if (tgl_phase >= tgl_period) begin
                    tgl_phase = 0;
                    cut_tgl   = ~cut_tgl;
                end
            end
        end
    end

    task automatic wait_done(input int budget, output int cycles, output bit hit);
        cycles = 0;
        hit    = 0;
        while (cycles < budget && !hit) begin
            @(negedge clk);
            cycles++;
            if (meas_done === 1'b1) hit = 1;
        end
    endtask

    task automatic expect_done(input string name, input int want_cycles);
        int c;
        bit h;
        wait_done(300, c, h);
        check_output({name, "_seen"}, 32'(h), 32'd1);
        if (want_cycles > 0) check_output({name, "_gap"}, 32'(c), 32'(want_cycles));
    endtask

    task automatic pulse_clear();
        @(posedge clk); #2 err_clear = 1'b1;
        @(posedge clk); #2 err_clear = 1'b0;
    endtask

    task automatic apply_stimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 149) == 0) tgl_period = $urandom_range(0, 5);
            enable    = ($urandom_range(0, 299) != 0);
            err_clear = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk); #2 err_clear = 1'b0; enable = 1'b1;
    endtask

    initial begin
        logic [CNT_W-1:0] saved_store;
        logic [7:0]       saved_wins;
        int               c;
        bit               h;

        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_status", 32'(core_status), 32'd0);
        @(posedge clk); #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_output("idle_status", 32'(core_status), 32'd0);
        check_output("idle_store", 32'(cut_count_store), 32'd0);
        check_output("idle_reftc", 32'(ref_clk_tc_reg), 32'd0);
        check_output("idle_err_done", {30'd0, clk_err, meas_done}, 32'd0);

        // nominal ~50 edges per window
        tgl_period = 2;
        @(posedge clk); #2 enable = 1'b1;
        expect_done("first_window", 103);
        check_output("nom1_range", 32'(cut_count_store >= 49 && cut_count_store <= 51), 32'd1);
        expect_done("second_window", 101);
        check_output("nom2_range", 32'(cut_count_store >= 49 && cut_count_store <= 51), 32'd1);
        check_output("nom_reftc", 32'(ref_clk_tc_reg), 32'd100);
        check_output("nom_err", 32'(clk_err), 32'd0);
        check_output("nom_valid", 32'(core_status[4]), 32'd1);

        // slow CUT: too low, error after two windows, then a pass clears fail_cnt only
        tgl_period = 3;
        expect_done("slow1", 101);
        check_output("slow1_low", 32'(core_status[2]), 32'd1);
        check_output("slow1_failcnt", 32'(core_status[15:8]), 32'd1);
        check_output("slow1_err", 32'(clk_err), 32'd0);
        expect_done("slow2", 101);
        check_output("slow2_err", 32'(clk_err), 32'd1);
        check_output("slow2_failcnt", 32'(core_status[15:8]), 32'd2);
        tgl_period = 2;
        expect_done("recover", 101);
        check_output("recover_failcnt", 32'(core_status[15:8]), 32'd0);
        check_output("recover_err_sticky", 32'(clk_err), 32'd1);

        // fast CUT, then stuck CUT, then err_clear
        tgl_period = 1;
        expect_done("fast", 101);
        check_output("fast_high", 32'(core_status[3]), 32'd1);
        tgl_period = 0;
        expect_done("stuck1", 101);
        expect_done("stuck2", 101);
        check_output("stuck_count", 32'(cut_count_store), 32'd0);
        check_output("stuck_low", 32'(core_status[2]), 32'd1);
        pulse_clear();
        @(negedge clk);
        check_output("clear_err", 32'(clk_err), 32'd0);
        check_output("clear_failcnt", 32'(core_status[15:8]), 32'd0);

        // abort at MEASURE cycle 40
        tgl_period = 2;
        expect_done("pre_abort1", 0);
        expect_done("pre_abort2", 101);
        saved_store = cut_count_store;
        saved_wins  = core_status[23:16];
        repeat (40) @(posedge clk);
        #2 enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("abort_running", 32'(core_status[0]), 32'd0);
        check_output("abort_state", 32'(core_status[6:5]), 32'd0);
        wait_done(150, c, h);
        check_output("abort_no_done", 32'(h), 32'd0);
        check_output("abort_store_hold", 32'(cut_count_store), 32'(saved_store));
        check_output("abort_wins_hold", 32'(core_status[23:16]), 32'(saved_wins));
        @(posedge clk); #2 enable = 1'b1;
        expect_done("reenable", 103);

        // err_clear coinciding with the EVAL that reaches the threshold
        tgl_period = 0;
        expect_done("pre_coinc", 101);
        pulse_clear();
        expect_done("coinc_a", 0);
        check_output("coinc_a_failcnt", 32'(core_status[15:8]), 32'd1);
        check_output("coinc_a_err", 32'(clk_err), 32'd0);
        repeat (100) @(posedge clk);
        #2 err_clear = 1'b1;
        @(posedge clk); #2 err_clear = 1'b0;
        @(negedge clk);
        check_output("coinc_done", 32'(meas_done), 32'd1);
        check_output("coinc_err_wins", 32'(clk_err), 32'd1);
        check_output("coinc_failcnt", 32'(core_status[15:8]), 32'd2);

        // asynchronous reset in the middle of a window
        repeat (30) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_output("async_status", 32'(core_status), 32'd0);
        check_output("async_store", 32'(cut_count_store), 32'd0);
        check_output("async_reftc", 32'(ref_clk_tc_reg), 32'd0);
        check_output("async_err_done", {30'd0, clk_err, meas_done}, 32'd0);
        @(posedge clk); #2 reset = 1'b0;

        // randomized traffic checked cycle by cycle against the model
        apply_stimulus(4000);
        repeat (5) @(negedge clk);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
